instruction_fetch_unit: RTL and testbench



---
 rtl/cpu_pkg.sv | 27 ++
 rtl/instruction_fetch_unit_if.sv | 32 +++
 rtl/fetch_queue.sv | 78 +++++++
 rtl/instruction_fetch_unit.sv | 88 ++++++++
 tb/tb_instruction_fetch_unit.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch/decode definitions: default widths, fetch FSM encoding and
// instruction field positions that the decoder slices out of each word.
package cpu_pkg;

  localparam int PC_WIDTH_DEF    = 8;
  localparam int INSTR_WIDTH_DEF = 6;

  localparam int OPC_MSB = 4;
  localparam int OPC_LSB = 2;
  localparam int REG_MSB = 1;
  localparam int REG_LSB = 0;

  typedef enum logic [1:0] {
    FETCH_BOOT = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_HALT = 2'd2
  } fetch_state_e;

  function automatic logic [OPC_MSB-OPC_LSB:0] instr_opcode(input logic [INSTR_WIDTH_DEF-1:0] ins);
    return ins[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [REG_MSB-REG_LSB:0] instr_reg(input logic [INSTR_WIDTH_DEF-1:0] ins);
    return ins[REG_MSB:REG_LSB];
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch unit bus: ROM read port, instruction valid/ready stream to the decoder,
// and the jump/halt control inputs. master = fetch unit, slave = its environment.
interface instruction_fetch_unit_if
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH    = PC_WIDTH_DEF,
  parameter int INSTR_WIDTH = INSTR_WIDTH_DEF
) ();

  logic [PC_WIDTH-1:0]    mem_addr;
  logic                   mem_rd_en;
  logic [INSTR_WIDTH-1:0] mem_rdata;
  logic [INSTR_WIDTH-1:0] instruction;
  logic [PC_WIDTH-1:0]    instr_pc;
  logic                   instr_valid;
  logic                   instr_ready;
  logic                   jump_en;
  logic [PC_WIDTH-1:0]    jump_addr;
  logic                   halt_req;
  logic                   halted;

  modport master (
    output mem_addr, mem_rd_en, instruction, instr_pc, instr_valid, halted,
    input  mem_rdata, instr_ready, jump_en, jump_addr, halt_req
  );

  modport slave (
    input  mem_addr, mem_rd_en, instruction, instr_pc, instr_valid, halted,
    output mem_rdata, instr_ready, jump_en, jump_addr, halt_req
  );

endinterface

// File: rtl/fetch_queue.sv
// 2-entry {pc, instruction} FIFO with registered head (no fall-through).
// Push lands one cycle later at the head; flush empties it; push into a full queue is illegal.
module fetch_queue #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [PC_WIDTH-1:0]    pc_i,
  input  logic [INSTR_WIDTH-1:0] instr_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output logic                   vld_o,
  output logic [PC_WIDTH-1:0]    pc_o,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [1:0]             count_o
);

  logic [1:0]             count_q;
  logic [PC_WIDTH-1:0]    pc0_q, pc1_q;
  logic [INSTR_WIDTH-1:0] ins0_q, ins1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      pc0_q   <= '0;
      pc1_q   <= '0;
      ins0_q  <= '0;
      ins1_q  <= '0;
    end else if (flush_i) begin
      count_q <= 2'd0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (count_q == 2'd0) begin
            pc0_q  <= pc_i;
            ins0_q <= instr_i;
          end else begin
            pc1_q  <= pc_i;
            ins1_q <= instr_i;
          end
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          pc0_q   <= pc1_q;
          ins0_q  <= ins1_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the new entry goes wherever the tail now sits.
          if (count_q == 2'd1) begin
            pc0_q  <= pc_i;
            ins0_q <= instr_i;
          end else begin
            pc0_q  <= pc1_q;
            ins0_q <= ins1_q;
            pc1_q  <= pc_i;
            ins1_q <= instr_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !flush_i) begin
      assert (!(push_i && !pop_i && count_q == 2'd2));
    end
  end

  assign vld_o   = (count_q != 2'd0);
  assign pc_o    = pc0_q;
  assign instr_o = ins0_q;
  assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// PC, BOOT/RUN/HALT FSM and ROM read tagging in front of a 2-entry fetch queue.
// Issue->valid is 2 cycles; reads stop once queued plus in-flight words would exceed two.
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH    = PC_WIDTH_DEF,
  parameter int INSTR_WIDTH = INSTR_WIDTH_DEF
) (
  input logic                      clk,
  input logic                      rst_n,
  instruction_fetch_unit_if.master bus
);

  fetch_state_e           state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, tag_q;
  logic                   inflight_q, halted_q;

  logic                   q_vld;
  logic [PC_WIDTH-1:0]    q_pc;
  logic [INSTR_WIDTH-1:0] q_instr;
  logic [1:0]             q_count, count_d;
  logic [2:0]             occ;
  logic                   pop, push, issue;

  assign pop  = q_vld & bus.instr_ready;
  // A jump drops the word returning this cycle; it belongs to the old path.
  assign push = inflight_q & ~bus.jump_en;
  assign occ  = {1'b0, q_count} + {2'b00, inflight_q} - {2'b00, pop};
  // Strobe is decided in-cycle from pop so a full-rate stream fits in two entries.
  assign issue   = (state_q == FETCH_RUN) && !bus.jump_en && (occ <= 3'd1);
  assign count_d = bus.jump_en ? 2'd0 : (q_count + {1'b0, push} - {1'b0, pop});

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH_BOOT: state_d = FETCH_RUN;
      FETCH_RUN:  if (bus.halt_req) state_d = FETCH_HALT;
      FETCH_HALT: state_d = FETCH_HALT;
      default:    state_d = FETCH_BOOT;
    endcase
    if (bus.jump_en) state_d = FETCH_RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH_BOOT;
      pc_q       <= '0;
      tag_q      <= '0;
      inflight_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      halted_q   <= (state_d == FETCH_HALT) && (count_d == 2'd0) && !issue;
      if (bus.jump_en) begin
        pc_q <= bus.jump_addr;
      end else if (issue) begin
        pc_q  <= pc_q + PC_WIDTH'(1);
        tag_q <= pc_q;
      end
    end
  end

  fetch_queue #(
    .PC_WIDTH    (PC_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pc_i    (tag_q),
    .instr_i (bus.mem_rdata),
    .pop_i   (pop),
    .flush_i (bus.jump_en),
    .vld_o   (q_vld),
    .pc_o    (q_pc),
    .instr_o (q_instr),
    .count_o (q_count)
  );

  assign bus.mem_rd_en   = issue;
  assign bus.mem_addr    = pc_q;
  assign bus.instr_valid = q_vld;
  assign bus.instruction = q_instr;
  assign bus.instr_pc    = q_pc;
  assign bus.halted      = halted_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: ROM[i] = i & 6'h3F, cycle-by-cycle checks
// of stream, backpressure, jump, halt, wrap/priority and asynchronous reset.
module tb_instruction_fetch_unit;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] rom_q = '0;
  int         n_cmp = 0;
  int         n_err = 0;

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_rd_en) rom_q <= bus.mem_addr[5:0];
  end
  assign bus.mem_rdata = rom_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic rdy, input logic jmp, input logic [7:0] ja, input logic hlt);
    @(posedge clk);
    #1;
    bus.instr_ready = rdy;
    bus.jump_en     = jmp;
    bus.jump_addr   = ja;
    bus.halt_req    = hlt;
    #1;
  endtask

  task automatic head(input string tag, input logic [7:0] pc);
    logic [7:0] ins;
    ins = pc & 8'h3F;
    chk({tag, ".vld"}, 32'(bus.instr_valid), 32'd1);
    chk({tag, ".pc"},  32'(bus.instr_pc),    32'(pc));
    chk({tag, ".ins"}, 32'(bus.instruction), 32'(ins));
  endtask

  task automatic rd(input string tag, input logic en, input logic [7:0] addr);
    chk({tag, ".rd_en"}, 32'(bus.mem_rd_en), 32'(en));
    if (en) chk({tag, ".addr"}, 32'(bus.mem_addr), 32'(addr));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".vld"},    32'(bus.instr_valid), 32'd0);
    chk({tag, ".ins"},    32'(bus.instruction), 32'd0);
    chk({tag, ".pc"},     32'(bus.instr_pc),    32'd0);
    chk({tag, ".rd_en"},  32'(bus.mem_rd_en),   32'd0);
    chk({tag, ".addr"},   32'(bus.mem_addr),    32'd0);
    chk({tag, ".halted"}, 32'(bus.halted),      32'd0);
  endtask

  // Leaves the bench in cycle 0 (BOOT) with instr_ready high.
  task automatic release_rst();
    @(posedge clk);
    #1;
    rst_n           = 1'b1;
    bus.instr_ready = 1'b1;
    bus.jump_en     = 1'b0;
    bus.jump_addr   = '0;
    bus.halt_req    = 1'b0;
    #1;
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.instr_ready = 1'b0;
    bus.jump_en     = 1'b0;
    bus.jump_addr   = '0;
    bus.halt_req    = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk_reset("rst");

    // Stream: BOOT in cycle 0, issue from cycle 1, head k-3 in cycle k
    release_rst();
    rd("c0", 1'b0, 8'h00);
    chk("c0.vld", 32'(bus.instr_valid), 32'd0);
    cyc(1, 0, 8'h00, 0); rd("c1", 1'b1, 8'h00);
    cyc(1, 0, 8'h00, 0); rd("c2", 1'b1, 8'h01);
    chk("c2.vld", 32'(bus.instr_valid), 32'd0);
    for (int k = 3; k <= 6; k++) begin
      cyc(1, 0, 8'h00, 0);
      head($sformatf("s%0d", k), 8'(k - 3));
      rd($sformatf("s%0d", k), 1'b1, 8'(k - 1));
    end

    // Backpressure: head 4 held for 5 cycles, queue fills with 4,5, reads stop
    for (int k = 7; k <= 11; k++) begin
      cyc(0, 0, 8'h00, 0);
      head($sformatf("bp%0d", k), 8'h04);
      rd($sformatf("bp%0d", k), 1'b0, 8'h00);
    end
    cyc(1, 0, 8'h00, 0); head("bp12", 8'h04); rd("bp12", 1'b1, 8'h06);
    cyc(1, 0, 8'h00, 0); head("bp13", 8'h05);
    cyc(1, 0, 8'h00, 0); head("bp14", 8'h06);

    // Jump while head 7 is popped; target valid three cycles later
    cyc(1, 1, 8'h40, 0); head("j15", 8'h07); rd("j15", 1'b0, 8'h00);
    cyc(1, 0, 8'h00, 0); rd("j16", 1'b1, 8'h40);
    chk("j16.vld", 32'(bus.instr_valid), 32'd0);
    cyc(1, 0, 8'h00, 0); chk("j17.vld", 32'(bus.instr_valid), 32'd0);
    cyc(1, 0, 8'h00, 0); head("j18", 8'h40);
    cyc(1, 0, 8'h00, 0); head("j19", 8'h41);

    // Halt: queued and in-flight words drain, then halted
    cyc(1, 0, 8'h00, 1); head("h20", 8'h42);
    cyc(1, 0, 8'h00, 0); head("h21", 8'h43); rd("h21", 1'b0, 8'h00);
    chk("h21.halted", 32'(bus.halted), 32'd0);
    cyc(1, 0, 8'h00, 0); head("h22", 8'h44); rd("h22", 1'b0, 8'h00);
    chk("h22.halted", 32'(bus.halted), 32'd0);
    cyc(1, 0, 8'h00, 0); rd("h23", 1'b0, 8'h00);
    chk("h23.vld", 32'(bus.instr_valid), 32'd0);
    chk("h23.halted", 32'(bus.halted), 32'd1);
    cyc(1, 0, 8'h00, 0); chk("h24.halted", 32'(bus.halted), 32'd1);
    cyc(1, 1, 8'h10, 0); rd("h25", 1'b0, 8'h00);
    chk("h25.halted", 32'(bus.halted), 32'd1);
    cyc(1, 0, 8'h00, 0); rd("h26", 1'b1, 8'h10);
    chk("h26.halted", 32'(bus.halted), 32'd0);
    cyc(1, 0, 8'h00, 0); chk("h27.vld", 32'(bus.instr_valid), 32'd0);
    cyc(1, 0, 8'h00, 0); head("h28", 8'h10);
    cyc(1, 0, 8'h00, 0); head("h29", 8'h11);

    // Wrap: FE, FF, 00, 01
    cyc(1, 1, 8'hFE, 0); head("w30", 8'h12);
    cyc(1, 0, 8'h00, 0); rd("w31", 1'b1, 8'hFE);
    cyc(1, 0, 8'h00, 0); rd("w32", 1'b1, 8'hFF);
    cyc(1, 0, 8'h00, 0); head("w33", 8'hFE); rd("w33", 1'b1, 8'h00);
    cyc(1, 0, 8'h00, 0); head("w34", 8'hFF);
    chk("w34.opcode", 32'(instr_opcode(bus.instruction)), 32'd7);
    chk("w34.reg", 32'(instr_reg(bus.instruction)), 32'd3);
    cyc(1, 0, 8'h00, 0); head("w35", 8'h00);

    // jump_en and halt_req together: jump wins, fetch continues at 0x20
    cyc(1, 1, 8'h20, 1); head("p36", 8'h01);
    cyc(1, 0, 8'h00, 0); rd("p37", 1'b1, 8'h20);
    chk("p37.halted", 32'(bus.halted), 32'd0);
    cyc(1, 0, 8'h00, 0); rd("p38", 1'b1, 8'h21);
    chk("p38.vld", 32'(bus.instr_valid), 32'd0);
    cyc(1, 0, 8'h00, 0); head("p39", 8'h20);
    cyc(1, 0, 8'h00, 0); head("p40", 8'h21);

    // Asynchronous reset with a queued word and a read in flight
    cyc(0, 0, 8'h00, 0); head("a41", 8'h22);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset("arst");
    repeat (2) @(posedge clk);
    release_rst();
    rd("r0", 1'b0, 8'h00);
    cyc(1, 0, 8'h00, 0); rd("r1", 1'b1, 8'h00);
    cyc(1, 0, 8'h00, 0); chk("r2.vld", 32'(bus.instr_valid), 32'd0);
    cyc(1, 0, 8'h00, 0); head("r3", 8'h00);
    cyc(1, 0, 8'h00, 0); head("r4", 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
